// File: rtl/pong_draw_pkg.sv
// Shared constants for the pong draw path: screen geometry, default field
// widths, requester indices and the draw arbiter state encoding.
package pong_draw_pkg;

  // Default coordinate / colour field widths
  localparam int DEF_X_W   = 8;
  localparam int DEF_Y_W   = 7;
  localparam int DEF_COL_W = 3;

  // Visible screen size in pixels
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Requester slots on the draw arbiter
  localparam int REQ_CLEAR = 0;
  localparam int REQ_LPAD  = 1;
  localparam int REQ_RPAD  = 2;
  localparam int REQ_BALL  = 3;

  // Arbiter state encoding
  typedef logic [1:0] draw_state_t;
  localparam draw_state_t ST_IDLE = 2'd0;
  localparam draw_state_t ST_DRAW = 2'd1;
  localparam draw_state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set req bit at or after ptr,
// wrapping around. Produces a one-hot winner, its index and an any_req flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               any_req
);

  // Scan from ptr upwards (modulo NUM_REQ) and keep the first hit
  always_comb begin
    int idx;
    winner     = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    idx        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Draw arbiter: shares the VGA adapter write port among NUM_REQ rectangle
// drawers. A round-robin winner's rectangle is latched and scanned one pixel
// per clock in raster order. The first pixel is driven in the grant cycle,
// the done pulse follows the last pixel, then one idle cycle precedes the
// next grant.
// Optional build macro DRAW_ARB_CLIP_EN: pixels falling outside the visible
// screen are scanned with plot = 0 instead of wrapping onto the screen.
module draw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = pong_draw_pkg::DEF_X_W,
  parameter int Y_W     = pong_draw_pkg::DEF_Y_W,
  parameter int COL_W   = pong_draw_pkg::DEF_COL_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*X_W-1:0]   req_w,
  input  logic [NUM_REQ*Y_W-1:0]   req_h,
  input  logic [NUM_REQ*COL_W-1:0] req_col,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     plot
);
  import pong_draw_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  // Per-requester rectangle fields
  logic [X_W-1:0]   f_x   [NUM_REQ];
  logic [Y_W-1:0]   f_y   [NUM_REQ];
  logic [X_W-1:0]   f_w   [NUM_REQ];
  logic [Y_W-1:0]   f_h   [NUM_REQ];
  logic [COL_W-1:0] f_col [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign f_x[gi]   = req_x[gi*X_W +: X_W];
      assign f_y[gi]   = req_y[gi*Y_W +: Y_W];
      assign f_w[gi]   = req_w[gi*X_W +: X_W];
      assign f_h[gi]   = req_h[gi*Y_W +: Y_W];
      assign f_col[gi] = req_col[gi*COL_W +: COL_W];
    end
  endgenerate

  draw_state_t        state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [NUM_REQ-1:0] sel_reg;
  logic [X_W-1:0]     x0_reg, w_reg, cx_reg;
  logic [Y_W-1:0]     y0_reg, h_reg, cy_reg;
  logic [COL_W-1:0]   col_reg;
  logic [NUM_REQ-1:0] grant_reg, done_reg;
  logic               busy_reg, plot_reg;
  logic [X_W-1:0]     vga_x_reg;
  logic [Y_W-1:0]     vga_y_reg;
  logic [COL_W-1:0]   vga_col_reg;

  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_idx, ptr_next;
  logic               any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req        (req),
    .ptr        (ptr_reg),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any_req    (any_req)
  );

  assign ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  // Current rectangle and scan position: the winner's live fields at (0,0)
  // while accepting in IDLE, otherwise the latched rectangle
  logic [X_W-1:0]   cur_x0, cur_w, cur_cx, nxt_cx;
  logic [Y_W-1:0]   cur_y0, cur_h, cur_cy, nxt_cy;
  logic [COL_W-1:0] cur_col;
  logic             zero_size, last_col, last_pix;

  always_comb begin
    cur_x0  = x0_reg;
    cur_y0  = y0_reg;
    cur_w   = w_reg;
    cur_h   = h_reg;
    cur_col = col_reg;
    cur_cx  = cx_reg;
    cur_cy  = cy_reg;
    if (state_reg == ST_IDLE) begin
      cur_x0  = f_x[win_idx];
      cur_y0  = f_y[win_idx];
      cur_w   = f_w[win_idx];
      cur_h   = f_h[win_idx];
      cur_col = f_col[win_idx];
      cur_cx  = '0;
      cur_cy  = '0;
    end
    zero_size = (cur_w == '0) || (cur_h == '0);
    last_col  = (cur_cx == cur_w - X_W'(1));
    last_pix  = last_col && (cur_cy == cur_h - Y_W'(1));
    nxt_cx    = last_col ? '0 : cur_cx + X_W'(1);
    nxt_cy    = last_col ? cur_cy + Y_W'(1) : cur_cy;
  end

  // Pixel coordinate and its write enable
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           pix_on;

`ifdef DRAW_ARB_CLIP_EN
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign sum_x  = {1'b0, cur_x0} + {1'b0, cur_cx};
  assign sum_y  = {1'b0, cur_y0} + {1'b0, cur_cy};
  assign pix_x  = sum_x[X_W-1:0];
  assign pix_y  = sum_y[Y_W-1:0];
  assign pix_on = (int'(sum_x) < SCREEN_W) && (int'(sum_y) < SCREEN_H);
`else
  assign pix_x  = cur_x0 + cur_cx;
  assign pix_y  = cur_y0 + cur_cy;
  assign pix_on = 1'b1;
`endif

  // Arbitration, rectangle latch, raster scan and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      sel_reg     <= '0;
      x0_reg      <= '0;
      y0_reg      <= '0;
      w_reg       <= '0;
      h_reg       <= '0;
      col_reg     <= '0;
      cx_reg      <= '0;
      cy_reg      <= '0;
      grant_reg   <= '0;
      done_reg    <= '0;
      busy_reg    <= 1'b0;
      plot_reg    <= 1'b0;
      vga_x_reg   <= '0;
      vga_y_reg   <= '0;
      vga_col_reg <= '0;
    end else begin
      grant_reg <= '0;
      done_reg  <= '0;
      plot_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          // The cycle showing done is still part of the previous rectangle,
          // so a new grant waits for one more edge
          if (any_req && (done_reg == '0)) begin
            busy_reg  <= 1'b1;
            grant_reg <= win_onehot;
            sel_reg   <= win_onehot;
            ptr_reg   <= ptr_next;
            x0_reg    <= cur_x0;
            y0_reg    <= cur_y0;
            w_reg     <= cur_w;
            h_reg     <= cur_h;
            col_reg   <= cur_col;
            if (zero_size) begin
              cx_reg    <= '0;
              cy_reg    <= '0;
              state_reg <= ST_FIN;
            end else begin
              vga_x_reg   <= pix_x;
              vga_y_reg   <= pix_y;
              vga_col_reg <= cur_col;
              plot_reg    <= pix_on;
              cx_reg      <= nxt_cx;
              cy_reg      <= nxt_cy;
              state_reg   <= last_pix ? ST_FIN : ST_DRAW;
            end
          end
        end
        ST_DRAW: begin
          vga_x_reg   <= pix_x;
          vga_y_reg   <= pix_y;
          vga_col_reg <= cur_col;
          plot_reg    <= pix_on;
          cx_reg      <= nxt_cx;
          cy_reg      <= nxt_cy;
          if (last_pix) begin
            state_reg <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_reg  <= sel_reg;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_reg;
  assign done       = done_reg;
  assign busy       = busy_reg;
  assign plot       = plot_reg;
  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_colour = vga_col_reg;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed self-checking bench for draw_arbiter: reset state, single
// rectangle, round-robin contention, zero-size rectangle, reset mid-draw,
// full-screen clear and the off-screen clipping case.
module tb_draw_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

`ifdef DRAW_ARB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic [N*XW-1:0] req_x, req_w;
  logic [N*YW-1:0] req_y, req_h;
  logic [N*CW-1:0] req_col;
  logic [N-1:0]  grant, done;
  logic          busy, plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  int n_checks = 0;
  int n_fail   = 0;
  int px_x[$];
  int px_y[$];
  int px_c[$];

  draw_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_col    (req_col),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int w,
                         input int h, input int c);
    req_x[i*XW +: XW]   = XW'(x);
    req_y[i*YW +: YW]   = YW'(y);
    req_w[i*XW +: XW]   = XW'(w);
    req_h[i*YW +: YW]   = YW'(h);
    req_col[i*CW +: CW] = CW'(c);
  endtask

  // Advance until a grant shows up (bounded) and check which one it is
  task automatic wait_grant(input logic [N-1:0] exp, input string tag, output int waited);
    waited = 0;
    while (grant == '0 && waited < 60) begin
      tick();
      waited++;
    end
    check({tag, "_grant"}, int'(grant), int'(exp));
  endtask

  // From the grant cycle, record plotted pixels until done (bounded)
  task automatic collect(input logic [N-1:0] exp_done, input string tag, input int budget,
                         output int nplot, output int cycles);
    px_x.delete();
    px_y.delete();
    px_c.delete();
    nplot  = 0;
    cycles = 0;
    forever begin
      if (plot) begin
        px_x.push_back(int'(vga_x));
        px_y.push_back(int'(vga_y));
        px_c.push_back(int'(vga_colour));
        nplot++;
      end
      if (cycles == 1) check({tag, "_grant_pulse"}, int'(grant), 0);
      if (done != '0 || cycles >= budget) break;
      tick();
      cycles++;
    end
    check({tag, "_done"}, int'(done), int'(exp_done));
    $display("rect %s: done=%b plots=%0d cycles=%0d", tag, done, nplot, cycles);
  endtask

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  int waited, nplot, cycles, n_done, exp_n;

  initial begin
    resetn = 1'b0;
    req    = '0;
    req_x  = '0;
    req_y  = '0;
    req_w  = '0;
    req_h  = '0;
    req_col = '0;

    // Reset state
    tick();
    tick();
    check("rst_grant", int'(grant), 0);
    check("rst_done",  int'(done), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_plot",  int'(plot), 0);
    check("rst_x",     int'(vga_x), 0);
    check("rst_y",     int'(vga_y), 0);
    check("rst_col",   int'(vga_colour), 0);
    resetn = 1'b1;

    // Single 2x2 rectangle on requester 1
    set_req(1, 10, 20, 2, 2, 3);
    req = 4'b0010;
    wait_grant(4'b0010, "t1", waited);
    req = '0;
    check("t1_busy_grant", int'(busy), 1);
    collect(4'b0010, "t1", 20, nplot, cycles);
    check("t1_nplot", nplot, 4);
    check("t1_cycles", cycles, 4);
    check("t1_p0x", qget(px_x, 0), 10); check("t1_p0y", qget(px_y, 0), 20);
    check("t1_p1x", qget(px_x, 1), 11); check("t1_p1y", qget(px_y, 1), 20);
    check("t1_p2x", qget(px_x, 2), 10); check("t1_p2y", qget(px_y, 2), 21);
    check("t1_p3x", qget(px_x, 3), 11); check("t1_p3y", qget(px_y, 3), 21);
    for (int k = 0; k < 4; k++) check("t1_col", qget(px_c, k), 3);
    check("t1_busy_fin", int'(busy), 1);
    check("t1_plot_fin", int'(plot), 0);
    tick();
    check("t1_busy_after", int'(busy), 0);
    check("t1_done_after", int'(done), 0);

    // Contention after reset: 0 then 2, then 3 ahead of 0 with ptr=3
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    set_req(0, 1, 1, 1, 1, 5);
    set_req(2, 2, 2, 1, 2, 6);
    req = 4'b0101;
    wait_grant(4'b0001, "c0", waited);
    req = 4'b0100;
    collect(4'b0001, "c0", 20, nplot, cycles);
    check("c0_nplot", nplot, 1);
    wait_grant(4'b0100, "c2", waited);
    check("c2_spacing", waited, 2);
    set_req(3, 50, 60, 1, 1, 7);
    req = 4'b1001;
    collect(4'b0100, "c2", 20, nplot, cycles);
    check("c2_nplot", nplot, 2);
    check("c2_p1y", qget(px_y, 1), 3);
    wait_grant(4'b1000, "c3", waited);
    check("c3_spacing", waited, 2);
    req = 4'b0001;
    collect(4'b1000, "c3", 20, nplot, cycles);
    check("c3_px", qget(px_x, 0), 50);
    wait_grant(4'b0001, "c0b", waited);
    req = '0;
    collect(4'b0001, "c0b", 20, nplot, cycles);
    check("c0b_nplot", nplot, 1);

    // Zero width on requester 3
    set_req(3, 5, 5, 0, 5, 2);
    req = 4'b1000;
    wait_grant(4'b1000, "z3", waited);
    req = '0;
    collect(4'b1000, "z3", 20, nplot, cycles);
    check("z3_nplot", nplot, 0);
    check("z3_cycles", cycles, 1);

    // Reset in the middle of a 4x4
    tick();
    set_req(1, 30, 40, 4, 4, 2);
    req = 4'b0010;
    wait_grant(4'b0010, "r1", waited);
    req = '0;
    tick();
    tick();
    check("r1_plot_mid", int'(plot), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("r1_plot_rst", int'(plot), 0);
    check("r1_busy_rst", int'(busy), 0);
    check("r1_done_rst", int'(done), 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done != '0 || plot) n_done++;
    end
    check("r1_quiet", n_done, 0);
    set_req(2, 70, 80, 1, 1, 1);
    req = 4'b0100;
    wait_grant(4'b0100, "r2", waited);
    req = '0;
    collect(4'b0100, "r2", 20, nplot, cycles);
    check("r2_nplot", nplot, 1);
    check("r2_px", qget(px_x, 0), 70);

    // Full-screen clear
    tick();
    set_req(0, 0, 0, 160, 120, 1);
    req = 4'b0001;
    wait_grant(4'b0001, "clr", waited);
    req = '0;
    collect(4'b0001, "clr", 19300, nplot, cycles);
    check("clr_nplot", nplot, 19200);
    check("clr_first_x", qget(px_x, 0), 0);
    check("clr_first_y", qget(px_y, 0), 0);
    check("clr_last_x", qget(px_x, 19199), 159);
    check("clr_last_y", qget(px_y, 19199), 119);

    // Rectangle running off the right edge
    tick();
    set_req(1, 158, 5, 4, 1, 4);
    req = 4'b0010;
    wait_grant(4'b0010, "clip", waited);
    req = '0;
    collect(4'b0010, "clip", 20, nplot, cycles);
    exp_n = CLIP ? 2 : 4;
    check("clip_nplot", nplot, exp_n);
    check("clip_cycles", cycles, 4);
    for (int k = 0; k < exp_n; k++) check("clip_x", qget(px_x, k), 158 + k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) among NUM_REQ rectangle drawers: screen clear, left pad, right pad, ball.
- Each requester submits one rectangle (origin, size, colour).
- The block arbitrates round-robin, latches the winning rectangle, then scans it one pixel per clock in raster order.
- It sits between the game controller's draw sequencer and the VGA adapter. It replaces the per-object draw counters in the controller.

Parameters:
- NUM_REQ, 4, number of requesters (index 0 = clear, 1 = left pad, 2 = right pad, 3 = ball)
- X_W, 8, x coordinate and width field bits
- Y_W, 7, y coordinate and height field bits
- COL_W, 3, colour bits
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- req  in  NUM_REQ  per-requester draw request level
- req_x  in  NUM_REQ*X_W  rectangle origin x; slice i belongs to requester i
- req_y  in  NUM_REQ*Y_W  rectangle origin y
- req_w  in  NUM_REQ*X_W  rectangle width in pixels
- req_h  in  NUM_REQ*Y_W  rectangle height in pixels
- req_col  in  NUM_REQ*COL_W  fill colour
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted
- done  out  NUM_REQ  one-hot, one-cycle pulse when that rectangle is finished
- busy  out  1  high in any state other than IDLE
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_colour  out  COL_W  pixel colour
- plot  out  1  pixel write enable

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock clk.
  - On reset: state IDLE; grant, done, busy, plot = 0; vga_x, vga_y, vga_colour = 0; round-robin pointer = 0.
  - Reset mid-draw aborts the rectangle with no done pulse.
- All outputs are registered.
- States: IDLE, DRAW, FIN.
- IDLE:
  - If any req bit is high at an edge, select a winner round-robin: the first set bit at or after ptr, wrapping.
  - Latch its x, y, w, h, col. Set ptr = winner+1 mod NUM_REQ.
  - Clear the column/row counters cx, cy.
  - Go to DRAW, or to FIN if w==0 or h==0.
  - grant[winner] is high for exactly the first cycle after that edge.
  - No request: stay in IDLE, all pulses 0.
- DRAW, one pixel per cycle:
  - Outputs: vga_x = x0+cx (X_W bits, modulo 2^X_W), vga_y = y0+cy (modulo 2^Y_W), vga_colour = col, plot = 1.
  - cx increments each cycle. At cx==w-1, cx returns to 0 and cy increments.
  - When cx==w-1 and cy==h-1, go to FIN.
  - Exactly w*h plot cycles. The first pixel appears in the same cycle as grant.
- FIN: one cycle with done[winner] = 1 and plot = 0, then return to IDLE.
  - Minimum spacing between consecutive rectangles is 2 cycles (FIN + IDLE).
- Requester protocol:
  - Hold req and the rectangle fields stable until grant. Fields may change after grant.
  - req still high after done is treated as a new request.
  - Deasserting req before grant withdraws it without side effects.
- Requests arriving during DRAW or FIN are ignored until IDLE. No queueing beyond the req level.
- Size fields are unsigned. w=0 or h=0 gives grant then done with zero plots.

Optional Feature:
- Macro: DRAW_ARB_CLIP_EN.
- Defined: coordinate sums are computed at X_W+1 and Y_W+1 bits. A pixel with x0+cx >= SCREEN_W or y0+cy >= SCREEN_H is driven with plot = 0 but still consumes its cycle. Cycle count and done timing are unchanged.
- Undefined: no clipping. Sums truncate to X_W and Y_W bits, and every DRAW cycle has plot = 1.

Decomposition:
- Package pong_draw_pkg holds:
  - the state enum (IDLE, DRAW, FIN)
  - SCREEN_W and SCREEN_H
  - default X_W, Y_W, COL_W
  - requester index constants: REQ_CLEAR=0, REQ_LPAD=1, REQ_RPAD=2, REQ_BALL=3
- One sub-module, rr_arbiter: NUM_REQ-wide combinational round-robin pick from req and ptr, producing a one-hot winner and an any_req flag.

Test Plan:
- Single rectangle: req[1] with x=10, y=20, w=2, h=2, col=3.
  - grant[1] 1 cycle.
  - 4 plot cycles at (10,20), (11,20), (10,21), (11,21), colour 3.
  - done[1] on the next cycle; busy low after.
- Contention: req[0] and req[2] both high in IDLE after reset.
  - Requester 0 is served first, then 2.
  - req[0] re-asserted during 2's draw is served after 2. Requester 3 is served before 0 if both pending with ptr=3.
- Degenerate size: w=0, h=5 on req[3] -> grant[3], then done[3] 1 cycle later, zero plot cycles.
- Reset during DRAW: resetn low for 1 cycle at pixel 3 of a 4x4 -> next cycle plot=0, busy=0, no done; a new request is accepted normally.
- Full clear: req[0] with x=0, y=0, w=160, h=120 -> exactly 19200 plot cycles, last pixel (159,119), then done[0].
- Clipping: x=158, y=5, w=4, h=1.
  - With DRAW_ARB_CLIP_EN: plot only at x=158,159; 4 DRAW cycles total.
  - Without: plot at x=158..161.
